// File: rtl/branch_compare_pipe.sv
// Two-stage branch comparator: S1 holds operands, S2 holds flags; 2-cycle latency.
// Valid/ready: a full S2 stalls on !Out_ready; In_ready falls only when both stages are full.
module branch_compare_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [2:0]       Op,
  input  logic [TAG_W-1:0] Tag,
  input  logic             Flush,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [TAG_W-1:0] Out_tag,
  output logic             Taken,
  output logic             Eq,
  output logic             Lt,
  output logic             Gt,
  output logic             Zero,
  input  logic             Count_clr,
  output logic [CNT_W-1:0] Taken_count
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b010,
    OP_GE  = 3'b011,
    OP_LTU = 3'b100,
    OP_GEU = 3'b101,
    OP_GT  = 3'b110,
    OP_GTU = 3'b111
  } op_e;

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic gt;
    logic zero;
  } flags_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_reg1_q,  s1_reg1_d;
  logic [WIDTH-1:0] s1_reg2_q,  s1_reg2_d;
  op_e              s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  flags_t           s2_flags_q, s2_flags_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic             in_hs, out_hs;
  logic             signed_cmp;
  logic [WIDTH-1:0] a_cmp, b_cmp;
  flags_t           s1_flags;

  always_comb begin
    s2_adv = !s2_valid_q || Out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    in_hs  = In_valid && s1_adv;
    out_hs = s2_valid_q && Out_ready;
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so a single magnitude comparator serves both signednesses.
  always_comb begin
    signed_cmp = (s1_op_q == OP_LT) || (s1_op_q == OP_GE) || (s1_op_q == OP_GT);
    a_cmp      = s1_reg1_q ^ {signed_cmp, {(WIDTH-1){1'b0}}};
    b_cmp      = s1_reg2_q ^ {signed_cmp, {(WIDTH-1){1'b0}}};

    s1_flags       = '0;
    s1_flags.eq    = (s1_reg1_q == s1_reg2_q);
    s1_flags.lt    = (a_cmp < b_cmp);
    s1_flags.gt    = !s1_flags.eq && !s1_flags.lt;
    s1_flags.zero  = (s1_reg1_q == '0);

    unique case (s1_op_q)
      OP_EQ:          s1_flags.taken = s1_flags.eq;
      OP_NE:          s1_flags.taken = !s1_flags.eq;
      OP_LT, OP_LTU:  s1_flags.taken = s1_flags.lt;
      OP_GE, OP_GEU:  s1_flags.taken = !s1_flags.lt;
      OP_GT, OP_GTU:  s1_flags.taken = s1_flags.gt;
      default:        s1_flags.taken = 1'b0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_adv ? in_hs : s1_valid_q;
    s1_reg1_d  = s1_reg1_q;
    s1_reg2_d  = s1_reg2_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (in_hs) begin
      s1_reg1_d = Reg1;
      s1_reg2_d = Reg2;
      s1_op_d   = op_e'(Op);
      s1_tag_d  = Tag;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_tag_d   = s2_tag_q;
    s2_flags_d = s2_flags_q;
    if (s2_adv && s1_valid_q) begin
      s2_tag_d   = s1_tag_q;
      s2_flags_d = s1_flags;
    end

    // A flush squashes occupancy only; the result handed off this cycle was seen and still counts.
    if (Flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (Count_clr) begin
      cnt_d = '0;
    end else if (out_hs && s2_flags_q.taken && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid_q <= 1'b0;
      s1_reg1_q  <= '0;
      s1_reg2_q  <= '0;
      s1_op_q    <= OP_EQ;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_flags_q <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_reg1_q  <= s1_reg1_d;
      s1_reg2_q  <= s1_reg2_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      s2_flags_q <= s2_flags_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    In_ready    = s1_adv;
    Out_valid   = s2_valid_q;
    Out_tag     = s2_tag_q;
    Taken       = s2_flags_q.taken;
    Eq          = s2_flags_q.eq;
    Lt          = s2_flags_q.lt;
    Gt          = s2_flags_q.gt;
    Zero        = s2_flags_q.zero;
    Taken_count = cnt_q;
  end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Bench for branch_compare_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_branch_compare_pipe;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [31:0] Reg1 = '0;
  logic [31:0] Reg2 = '0;
  logic [2:0]  Op = '0;
  logic [4:0]  Tag = '0;
  logic        Flush = 1'b0;
  logic        Out_valid;
  logic        Out_ready = 1'b0;
  logic [4:0]  Out_tag;
  logic        Taken, Eq, Lt, Gt, Zero;
  logic        Count_clr = 1'b0;
  logic [3:0]  Taken_count;

  branch_compare_pipe #(.WIDTH(32), .TAG_W(5), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready),
    .Reg1(Reg1), .Reg2(Reg2), .Op(Op), .Tag(Tag), .Flush(Flush),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_tag(Out_tag),
    .Taken(Taken), .Eq(Eq), .Lt(Lt), .Gt(Gt), .Zero(Zero),
    .Count_clr(Count_clr), .Taken_count(Taken_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] tag;
    logic [4:0] flags; // {taken, eq, lt, gt, zero}
    int         acc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cnt_m = 0;
  bit         chk_lat = 0;
  bit         last_in_hs, last_out_hs, obs_in_ready, obs_out_valid;
  logic [4:0] obs_out_tag;
  logic [4:0] obs_flags;
  bit         hold_prev = 0;
  logic [4:0] prev_tag;
  logic [5:0] prev_bus;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op, input logic [4:0] tag);
    exp_t e;
    bit sgn, lt, gt, eq, tk;
    sgn = (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    gt  = sgn ? ($signed(a) > $signed(b)) : (a > b);
    eq  = (a == b);
    case (op)
      3'd0:       tk = eq;
      3'd1:       tk = !eq;
      3'd2, 3'd4: tk = lt;
      3'd3, 3'd5: tk = !lt;
      default:    tk = gt;
    endcase
    e.tag   = tag;
    e.flags = {tk, eq, lt, gt, (a == 32'd0)};
    e.acc   = cyc;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, settle, score the handshakes that the next rising edge will take.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [4:0] tag, input bit ordy, input bit fl, input bit clr);
    exp_t e;
    @(negedge Clk);
    check("taken_count", Taken_count, cnt_m);
    if (q.size() == 0) check("idle_out_valid", Out_valid, 0);
    if (hold_prev) begin
      check("hold_tag", Out_tag, prev_tag);
      check("hold_flags", {Out_valid, Taken, Eq, Lt, Gt, Zero}, prev_bus);
    end
    In_valid = iv; Reg1 = a; Reg2 = b; Op = op; Tag = tag;
    Out_ready = ordy; Flush = fl; Count_clr = clr;
    #1;
    obs_in_ready  = In_ready;
    obs_out_valid = Out_valid;
    obs_out_tag   = Out_tag;
    last_in_hs    = In_valid && In_ready;
    last_out_hs   = Out_valid && Out_ready;
    e.flags = '0;
    if (last_out_hs) begin
      if (q.size() == 0) begin
        check("unexpected_out", Out_valid, 0);
      end else begin
        e = q.pop_front();
        obs_flags = {Taken, Eq, Lt, Gt, Zero};
        check("out_tag", Out_tag, e.tag);
        check("out_flags", obs_flags, e.flags);
        if (chk_lat) check("latency", cyc - e.acc, 2);
      end
    end
    if (clr) cnt_m = 0;
    else if (last_out_hs && e.flags[4] && cnt_m < 15) cnt_m++;
    if (fl) q.delete();
    else if (last_in_hs) q.push_back(ref_model(a, b, op, tag));
    hold_prev = Out_valid && !Out_ready && !fl;
    prev_tag  = Out_tag;
    prev_bus  = {Out_valid, Taken, Eq, Lt, Gt, Zero};
    cyc++;
  endtask

  task automatic idle(input bit ordy);
    step(0, 32'd0, 32'd0, 3'd0, 5'd0, ordy, 0, 0);
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      idle(1);
      g++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t, g;
    logic [31:0] a, b;
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;

    // Reset held 2 cycles while requesting and flushing
    @(negedge Clk);
    Rst_n = 0; In_valid = 1; Flush = 1; Out_ready = 0; Reg1 = 32'h5; Reg2 = 32'h5;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_out_valid", Out_valid, 0);
    check("rst_in_ready", In_ready, 1);
    check("rst_count", Taken_count, 0);
    check("rst_flags", {Out_tag, Taken, Eq, Lt, Gt, Zero}, 0);
    Rst_n = 1; In_valid = 0; Flush = 0;
    q.delete(); cnt_m = 0; hold_prev = 0;

    // Signed vs unsigned, back to back
    chk_lat = 1;
    step(1, 32'hFFFF_FFFF, 32'd1, 3'b010, 5'd1, 1, 0, 0);
    check("sgn_accept1", last_in_hs, 1);
    step(1, 32'hFFFF_FFFF, 32'd1, 3'b100, 5'd2, 1, 0, 0);
    check("sgn_accept2", last_in_hs, 1);
    idle(1);
    check("lt_out_hs", last_out_hs, 1);
    check("lt_taken_lt_gt", {obs_flags[4], obs_flags[2], obs_flags[1]}, 3'b110);
    idle(1);
    check("ltu_out_hs", last_out_hs, 1);
    check("ltu_taken_lt_gt", {obs_flags[4], obs_flags[2], obs_flags[1]}, 3'b001);

    // Zero / equal corners
    step(1, 32'd0, 32'd0, 3'b001, 5'd3, 1, 0, 0);
    step(1, 32'd0, 32'd5, 3'b110, 5'd4, 1, 0, 0);
    idle(1);
    check("ne_zero_flags", obs_flags, 5'b01001);
    idle(1);
    check("gt_zero_flags", obs_flags, 5'b00101);
    chk_lat = 0;

    // Backpressure with tags 1..4
    step(0, 32'd0, 32'd0, 3'd0, 5'd0, 1, 0, 1);
    t = 1; g = 0;
    while (t <= 4 && g < 20) begin
      step(1, 32'd7, 32'd7, 3'b000, t[4:0], g >= 4, 0, 0);
      if (g == 2 || g == 3) begin
        check("bp_in_ready", obs_in_ready, 0);
        check("bp_out_tag", obs_out_tag, 1);
      end
      if (last_in_hs) t++;
      g++;
    end
    check("bp_all_accepted", t, 5);
    drain();
    @(negedge Clk);
    check("bp_count", Taken_count, 4);

    // Flush with two in flight and a third offered in the flush cycle
    step(0, 32'd0, 32'd0, 3'd0, 5'd0, 0, 0, 1);
    step(1, 32'd3, 32'd3, 3'b000, 5'd10, 0, 0, 0);
    step(1, 32'd4, 32'd4, 3'b000, 5'd11, 0, 0, 0);
    step(1, 32'd5, 32'd5, 3'b000, 5'd12, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("flush_no_out", obs_out_valid, 0);
    end
    check("flush_count", Taken_count, 0);

    // Saturation at 15, then clear beats a simultaneous increment
    for (int i = 0; i < 17; i++) step(1, 32'd9, 32'd9, 3'b000, i[4:0], 1, 0, 0);
    drain();
    @(negedge Clk);
    check("sat_count", Taken_count, 15);
    step(1, 32'd1, 32'd1, 3'b000, 5'd20, 1, 0, 0);
    idle(1);
    step(0, 32'd0, 32'd0, 3'd0, 5'd0, 1, 0, 1);
    check("clr_with_taken_hs", last_out_hs, 1);
    @(negedge Clk);
    check("clr_count", Taken_count, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = corners[$urandom_range(0, 4)];
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      step($urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)), 5'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0);
    end
    drain();
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
